// File: rtl/tile_map_ring.sv
// -----------------------------------------------------------------------------
// tile_map_ring
//   Scrolling playfield tile store. COLS x ROWS tiles are kept in a ring of
//   physical column slots; logical column i lives in slot (head+i) mod COLS, so
//   a scroll only rewrites one slot and advances head instead of shifting data.
//   New columns are fetched from the level source over a req/valid handshake.
//   NQ collision query channels plus one draw channel read the map with one
//   cycle of latency; hit events break bricks and spend question blocks.
//
// Optional feature: define TILE_MAP_STATS_EN to get a saturating 16-bit count
//   of broken bricks on bricks_broken (tied to 0 otherwise).
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   shift_req               pulse, scroll playfield one column left
//   ready                   initial fill done and controller idle
//   col_req, col_addr       column fetch request and level column address
//   col_data, col_valid     fetched column (row r at [r*TILE_W +: TILE_W])
//   drawX, drawY, draw_tile draw pixel and its tile (1-cycle latency)
//   q_x, q_y, q_tile        NQ query pixels (10 bits each) and their tiles
//   hit_valid, hit_x, hit_y hit event pulse and pixel
//   hit_done, hit_code      hit acknowledge pulse and pre-hit tile code
//   base_col                level address of logical column 0
//   bricks_broken           broken-brick counter (optional feature)
// -----------------------------------------------------------------------------
module tile_map_ring #(
    parameter int COLS      = 10,
    parameter int ROWS      = 10,
    parameter int TILE_W    = 3,
    parameter int TILE_PX   = 40,
    parameter int ORIGIN_X  = 120,
    parameter int ORIGIN_Y  = 40,
    parameter int NQ        = 6,
    parameter int CA_W      = 8,
    parameter int BRK_CODE  = 2,
    parameter int QST_CODE  = 3,
    parameter int USED_CODE = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   shift_req,
    output logic                   ready,
    output logic                   col_req,
    output logic [CA_W-1:0]        col_addr,
    input  logic [ROWS*TILE_W-1:0] col_data,
    input  logic                   col_valid,
    input  logic [9:0]             drawX,
    input  logic [9:0]             drawY,
    output logic [TILE_W-1:0]      draw_tile,
    input  logic [NQ*10-1:0]       q_x,
    input  logic [NQ*10-1:0]       q_y,
    output logic [NQ*TILE_W-1:0]   q_tile,
    input  logic                   hit_valid,
    input  logic [9:0]             hit_x,
    input  logic [9:0]             hit_y,
    output logic                   hit_done,
    output logic [TILE_W-1:0]      hit_code,
    output logic [CA_W-1:0]        base_col,
    output logic [15:0]            bricks_broken
);

    localparam int HW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [TILE_W-1:0]     r_tiles [COLS][ROWS];
    logic [HW-1:0]         r_head;
    logic [CA_W-1:0]       r_base;
    logic [CA_W-1:0]       r_init_cnt;
    logic                  r_col_req;
    logic [CA_W-1:0]       r_col_addr;
    logic                  r_pend;
    logic                  r_ready;
    logic [TILE_W-1:0]     r_draw_tile;
    logic [NQ*TILE_W-1:0]  r_q_tile;
    logic                  r_hit_done;
    logic [TILE_W-1:0]     r_hit_code;

    logic                  w_accept;
    logic [9:0]            w_wr_slot;
    logic [10:0]           w_hit_dc;
    logic [10:0]           w_hit_dr;
    logic [9:0]            w_hit_slot;
    logic                  w_hit_in;
    logic [TILE_W-1:0]     w_hit_old;
    logic [TILE_W-1:0]     w_hit_new;

    // Pixel coordinate to tile index along one axis: {in_range, index}.
    // Anything left of/above the origin or past the last tile is out of range.
    function automatic logic [10:0] f_decode_axis(input logic [9:0] p,
                                                  input int org, input int lim);
        logic [9:0] d;
        logic [9:0] i;
        if (p < 10'(org)) begin
            return 11'd0;
        end
        d = p - 10'(org);
        i = d / 10'(TILE_PX);
        if (i >= 10'(lim)) begin
            return 11'd0;
        end
        return {1'b1, i};
    endfunction

    // Logical column to physical ring slot.
    function automatic logic [9:0] f_slot(input logic [9:0] lcol);
        logic [9:0] s;
        s = 10'(r_head) + lcol;
        if (s >= 10'(COLS)) begin
            s = s - 10'(COLS);
        end
        return s;
    endfunction

    // Tile at a pixel; out-of-range pixels read as code 0.
    function automatic logic [TILE_W-1:0] f_read(input logic [9:0] x, input logic [9:0] y);
        logic [10:0]       dc;
        logic [10:0]       dr;
        logic [9:0]        slot;
        logic [TILE_W-1:0] t;
        t  = {TILE_W{1'b0}};
        dc = f_decode_axis(x, ORIGIN_X, COLS);
        dr = f_decode_axis(y, ORIGIN_Y, ROWS);
        if (dc[10] && dr[10]) begin
            slot = f_slot(dc[9:0]);
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (slot == 10'(c) && dr[9:0] == 10'(r)) begin
                        t = r_tiles[c][r];
                    end
                end
            end
        end
        return t;
    endfunction

    assign w_accept = r_col_req & col_valid;

    // During the initial fill head is 0, so logical column init_cnt maps
    // straight to its slot; a scroll fetch always refills the slot at head.
    assign w_wr_slot = (r_state == ST_INIT) ? f_slot(10'(r_init_cnt)) : 10'(r_head);

    // Hit decode and the tile code the hit turns the old code into.
    always_comb begin
        w_hit_dc   = f_decode_axis(hit_x, ORIGIN_X, COLS);
        w_hit_dr   = f_decode_axis(hit_y, ORIGIN_Y, ROWS);
        w_hit_slot = f_slot(w_hit_dc[9:0]);
        w_hit_in   = w_hit_dc[10] & w_hit_dr[10];
        w_hit_old  = f_read(hit_x, hit_y);
        w_hit_new  = w_hit_old;
        if (w_hit_old == TILE_W'(BRK_CODE)) begin
            w_hit_new = {TILE_W{1'b0}};
        end else if (w_hit_old == TILE_W'(QST_CODE)) begin
            w_hit_new = TILE_W'(USED_CODE);
        end else begin
            w_hit_new = w_hit_old;
        end
    end

    // Controller next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (w_accept && r_init_cnt == CA_W'(COLS - 1)) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (shift_req || r_pend) begin
                    w_next = ST_FETCH;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (w_accept) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            default: w_next = ST_INIT;
        endcase
    end

    // Controller state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Tile storage, ring pointers, fetch handshake and registered read ports.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_tiles[c][r] <= {TILE_W{1'b0}};
                end
            end
            r_head      <= {HW{1'b0}};
            r_base      <= {CA_W{1'b0}};
            r_init_cnt  <= {CA_W{1'b0}};
            r_col_req   <= 1'b0;
            r_col_addr  <= {CA_W{1'b0}};
            r_pend      <= 1'b0;
            r_ready     <= 1'b0;
            r_draw_tile <= {TILE_W{1'b0}};
            r_q_tile    <= {(NQ*TILE_W){1'b0}};
            r_hit_done  <= 1'b0;
            r_hit_code  <= {TILE_W{1'b0}};
        end else begin
            r_draw_tile <= f_read(drawX, drawY);
            for (int k = 0; k < NQ; k++) begin
                r_q_tile[k*TILE_W +: TILE_W] <= f_read(q_x[k*10 +: 10], q_y[k*10 +: 10]);
            end

            r_hit_done <= hit_valid;
            if (hit_valid) begin
                r_hit_code <= w_hit_old;
            end

            // Hit write first; a column commit to the same slot below
            // overrides it, so a concurrent fetch wins.
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (hit_valid && w_hit_in && w_hit_slot == 10'(c) &&
                        w_hit_dr[9:0] == 10'(r)) begin
                        r_tiles[c][r] <= w_hit_new;
                    end
                end
            end

            if (w_accept) begin
                for (int c = 0; c < COLS; c++) begin
                    if (w_wr_slot == 10'(c)) begin
                        for (int r = 0; r < ROWS; r++) begin
                            r_tiles[c][r] <= col_data[r*TILE_W +: TILE_W];
                        end
                    end
                end
                if (r_state == ST_INIT) begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                end else begin
                    r_head <= (r_head == HW'(COLS - 1)) ? {HW{1'b0}} : r_head + 1'b1;
                    r_base <= r_base + 1'b1;
                end
            end

            // Request drops after acceptance and is raised, with its address
            // latched, whenever the controller is (or is about to be) fetching.
            if (w_accept) begin
                r_col_req <= 1'b0;
            end else if (!r_col_req && w_next != ST_IDLE) begin
                r_col_req  <= 1'b1;
                r_col_addr <= (w_next == ST_INIT) ? r_init_cnt : r_base + CA_W'(COLS);
            end else begin
                r_col_req <= r_col_req;
            end

            // A single scroll request is remembered while busy; extras drop.
            if (r_state == ST_IDLE) begin
                r_pend <= 1'b0;
            end else if (shift_req) begin
                r_pend <= 1'b1;
            end else begin
                r_pend <= r_pend;
            end

            r_ready <= (w_next == ST_IDLE);
        end
    end

`ifdef TILE_MAP_STATS_EN
    logic [15:0] r_bricks;

    // Saturating count of bricks broken by hits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bricks <= 16'd0;
        end else if (hit_valid && w_hit_in && w_hit_old == TILE_W'(BRK_CODE) &&
                     r_bricks != 16'hFFFF) begin
            r_bricks <= r_bricks + 16'd1;
        end else begin
            r_bricks <= r_bricks;
        end
    end

    assign bricks_broken = r_bricks;
`else
    assign bricks_broken = 16'h0000;
`endif

    assign ready     = r_ready;
    assign col_req   = r_col_req;
    assign col_addr  = r_col_addr;
    assign draw_tile = r_draw_tile;
    assign q_tile    = r_q_tile;
    assign hit_done  = r_hit_done;
    assign hit_code  = r_hit_code;
    assign base_col  = r_base;

endmodule

// File: tb/tb_tile_map_ring.sv
// -----------------------------------------------------------------------------
// tb_tile_map_ring
//   Directed bench for tile_map_ring. A level source answers each column
//   request two cycles later with tile code (addr + row + 1) mod 8 per row.
// -----------------------------------------------------------------------------
module tb_tile_map_ring;

    localparam int COLS = 10;
    localparam int ROWS = 10;
    localparam int TW   = 3;
    localparam int NQ   = 6;
    localparam int CA_W = 8;

`ifdef TILE_MAP_STATS_EN
    localparam int EXP_BRICKS = 3;
`else
    localparam int EXP_BRICKS = 0;
`endif

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 shift_req = 1'b0;
    logic                 ready;
    logic                 col_req;
    logic [CA_W-1:0]      col_addr;
    logic [ROWS*TW-1:0]   col_data = '0;
    logic                 col_valid = 1'b0;
    logic [9:0]           drawX = 10'd0;
    logic [9:0]           drawY = 10'd0;
    logic [TW-1:0]        draw_tile;
    logic [NQ*10-1:0]     q_x = '0;
    logic [NQ*10-1:0]     q_y = '0;
    logic [NQ*TW-1:0]     q_tile;
    logic                 hit_valid = 1'b0;
    logic [9:0]           hit_x = 10'd0;
    logic [9:0]           hit_y = 10'd0;
    logic                 hit_done;
    logic [TW-1:0]        hit_code;
    logic [CA_W-1:0]      base_col;
    logic [15:0]          bricks_broken;

    int                   n_checks = 0;
    int                   n_fail = 0;
    logic                 src_en = 1'b0;
    logic [CA_W-1:0]      fetch_log[$];

    always #5 Clk = ~Clk;

    tile_map_ring dut (
        .Clk(Clk), .Reset(Reset), .shift_req(shift_req), .ready(ready),
        .col_req(col_req), .col_addr(col_addr), .col_data(col_data),
        .col_valid(col_valid), .drawX(drawX), .drawY(drawY),
        .draw_tile(draw_tile), .q_x(q_x), .q_y(q_y), .q_tile(q_tile),
        .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
        .hit_done(hit_done), .hit_code(hit_code), .base_col(base_col),
        .bricks_broken(bricks_broken)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [ROWS*TW-1:0] pat_col(input int a);
        logic [ROWS*TW-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            v[r*TW +: TW] = TW'((a + r + 1) % 8);
        end
        return v;
    endfunction

    // Level source: latch address, answer two cycles later for one cycle.
    initial begin : p_src
        logic [CA_W-1:0] a;
        forever begin
            tick();
            if (col_req && src_en) begin
                a = col_addr;
                fetch_log.push_back(a);
                tick();
                col_data  = pat_col(int'(a));
                col_valid = 1'b1;
                tick();
                col_valid = 1'b0;
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(ready), 32'd1);
    endtask

    task automatic do_shift();
        shift_req = 1'b1;
        tick();
        shift_req = 1'b0;
        wait_ready("shift_ready");
    endtask

    task automatic read_draw(input string tag, input int x, input int y, input int exp);
        drawX = 10'(x);
        drawY = 10'(y);
        tick();
        check_eq(tag, 32'(draw_tile), 32'(exp));
    endtask

    task automatic do_hit(input string tag, input int x, input int y,
                          input int exp_code, input int exp_after);
        hit_x     = 10'(x);
        hit_y     = 10'(y);
        hit_valid = 1'b1;
        tick();
        check_eq({tag, "_done"}, 32'(hit_done), 32'd1);
        check_eq({tag, "_code"}, 32'(hit_code), 32'(exp_code));
        hit_valid = 1'b0;
        tick();
        check_eq({tag, "_done_low"}, 32'(hit_done), 32'd0);
        read_draw({tag, "_after"}, x, y, exp_after);
    endtask

    task automatic set_q(input int ch, input int x, input int y);
        q_x[ch*10 +: 10] = 10'(x);
        q_y[ch*10 +: 10] = 10'(y);
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int n0;
        drawX = 10'd125;
        drawY = 10'd45;
        repeat (3) tick();
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_col_req", 32'(col_req), 32'd0);
        check_eq("rst_col_addr", 32'(col_addr), 32'd0);
        check_eq("rst_base", 32'(base_col), 32'd0);
        check_eq("rst_draw", 32'(draw_tile), 32'd0);
        check_eq("rst_q", 32'(q_tile), 32'd0);
        check_eq("rst_hit_done", 32'(hit_done), 32'd0);
        check_eq("rst_hit_code", 32'(hit_code), 32'd0);
        check_eq("rst_bricks", 32'(bricks_broken), 32'd0);

        // Initial fill
        Reset  = 1'b0;
        src_en = 1'b1;
        wait_ready("init_ready");
        check_eq("init_nfetch", 32'(fetch_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < fetch_log.size()) check_eq("init_addr", 32'(fetch_log[i]), 32'(i));
        end
        check_eq("init_base", 32'(base_col), 32'd0);
        read_draw("init_c0r0", 125, 45, 1);
        read_draw("init_c9r9", 485, 405, 3);

        // One scroll
        do_shift();
        check_eq("sh1_addr", 32'(fetch_log[fetch_log.size()-1]), 32'd10);
        check_eq("sh1_base", 32'(base_col), 32'd1);
        read_draw("sh1_c0", 120, 40, 2);
        read_draw("sh1_c9", 485, 40, 3);

        // Ten more scrolls: ring wraps
        repeat (10) do_shift();
        check_eq("sh11_addr", 32'(fetch_log[fetch_log.size()-1]), 32'd20);
        check_eq("sh11_base", 32'(base_col), 32'd11);
        read_draw("sh11_c9r0", 485, 40, 5);
        read_draw("sh11_c9r9", 485, 400, 6);

        // Hits (logical col c = addr 11+c, code = (12+c+r) mod 8)
        do_hit("hit_brk", 165, 245, 2, 0);
        do_hit("hit_qst", 205, 245, 3, 4);
        do_hit("hit_one", 165, 205, 1, 1);
        do_hit("hit_brk2", 205, 205, 2, 0);
        do_hit("hit_brk3", 245, 165, 2, 0);
        do_hit("hit_oor", 100, 100, 0, 0);
        check_eq("bricks", 32'(bricks_broken), 32'(EXP_BRICKS));

        // Query channels including out-of-range boundaries
        set_q(0, 119, 45);
        set_q(1, 520, 45);
        set_q(2, 125, 440);
        set_q(3, 125, 45);
        set_q(4, 519, 439);
        set_q(5, 160, 120);
        tick();
        check_eq("q0_x119", 32'(q_tile[0*TW +: TW]), 32'd0);
        check_eq("q1_x520", 32'(q_tile[1*TW +: TW]), 32'd0);
        check_eq("q2_y440", 32'(q_tile[2*TW +: TW]), 32'd0);
        check_eq("q3_c0r0", 32'(q_tile[3*TW +: TW]), 32'd4);
        check_eq("q4_c9r9", 32'(q_tile[4*TW +: TW]), 32'd6);
        check_eq("q5_c1r2", 32'(q_tile[5*TW +: TW]), 32'd7);

        // Shift held across IDLE + two FETCH cycles: exactly one extra fetch
        n0 = fetch_log.size();
        shift_req = 1'b1;
        repeat (3) tick();
        shift_req = 1'b0;
        repeat (40) tick();
        check_eq("pend_nfetch", 32'(fetch_log.size() - n0), 32'd2);
        check_eq("pend_addr0", 32'(fetch_log[n0]), 32'd21);
        check_eq("pend_addr1", 32'(fetch_log[n0+1]), 32'd22);
        check_eq("pend_base", 32'(base_col), 32'd13);
        check_eq("pend_ready", 32'(ready), 32'd1);

        // Reset while a fetch is outstanding
        src_en    = 1'b0;
        shift_req = 1'b1;
        tick();
        shift_req = 1'b0;
        check_eq("mid_col_req", 32'(col_req), 32'd1);
        check_eq("mid_col_addr", 32'(col_addr), 32'd23);
        Reset = 1'b1;
        drawX = 10'd125;
        drawY = 10'd45;
        tick();
        check_eq("rst2_col_req", 32'(col_req), 32'd0);
        check_eq("rst2_ready", 32'(ready), 32'd0);
        check_eq("rst2_base", 32'(base_col), 32'd0);
        check_eq("rst2_col_addr", 32'(col_addr), 32'd0);
        check_eq("rst2_bricks", 32'(bricks_broken), 32'd0);
        Reset = 1'b0;
        tick();
        check_eq("rst2_tiles", 32'(draw_tile), 32'd0);
        check_eq("rst2_req_addr", 32'(col_addr), 32'd0);
        fetch_log.delete();
        src_en = 1'b1;
        wait_ready("refill_ready");
        check_eq("refill_nfetch", 32'(fetch_log.size()), 32'd10);
        if (fetch_log.size() > 0) check_eq("refill_addr0", 32'(fetch_log[0]), 32'd0);
        read_draw("refill_c0r0", 125, 45, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
